rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Write-port controller for the RV32I register file. After reset it sequences a clear of every architectural register (x1..x31) through the single write port. It then arbitrates that port between two writeback requesters:
- requester 0: main pipeline writeback;
- requester 1: multi-cycle unit, e.g. load/divide.

It uses valid/ready handshakes and a starvation guard. Its outputs connect directly to the register file's `regWrite`, `writeAddr` and `dataIn` inputs.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive stalled cycles of requester 1 before it takes priority; legal range 1..15.
- `REGS`, `1 << RF_ADDR_WIDTH`: localparam, number of registers.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rstN`  in  1  reset; synchronous, active-low.
- `req0Valid`  in  1  pipeline write request.
- `req0Addr`  in  `RF_ADDR_WIDTH`  destination register.
- `req0Data`  in  `WORD_WIDTH`  write data.
- `req0Ready`  out  1  request 0 accepted this cycle (combinational).
- `req1Valid`  in  1  multi-cycle unit write request.
- `req1Addr`  in  `RF_ADDR_WIDTH`  destination register.
- `req1Data`  in  `WORD_WIDTH`  write data.
- `req1Ready`  out  1  request 1 accepted this cycle (combinational).
- `regWrite`  out  1  to register file write enable (registered).
- `writeAddr`  out  `RF_ADDR_WIDTH`  to register file (registered).
- `dataIn`  out  `WORD_WIDTH`  to register file (registered).
- `initDone`  out  1  clear sequence complete; port available.

## Operation
States:
- `CLEAR`: entered on reset.
  - Counter `clrCnt` starts at 1.
  - Each cycle the block presents `writeAddr=clrCnt`, `dataIn=0`, `regWrite=1`, then increments `clrCnt`.
  - After presenting address `REGS-1`, it moves to `RUN`.
  - Both readys are held 0 throughout.
- `RUN`: arbitration, one grant per cycle. The state is terminal until the next reset.

Arbitration in `RUN`:
- A request with address 0 needs no write. It gets ready=1 in the same cycle regardless of the other requester and does not occupy the port.
- When both requests target nonzero addresses, requester 0 wins by default.
- Requester 1 wins instead when `starveCnt == STARVE_LIMIT`.
- Only a winner with nonzero address drives the port: `regWrite=1`, `writeAddr`/`dataIn` taken from the winner.
- With no nonzero-address grant, `regWrite=0`. `writeAddr`/`dataIn` hold their previous values (don't-care).

`starveCnt` (4 bits) rules:
- Increments each cycle that requester 1 is valid with a nonzero address and is not granted.
- Saturates at `STARVE_LIMIT`.
- Clears on a requester 1 grant or when `req1Valid=0`.

Other rules:
- A same-address conflict needs no special handling. The loser is written in a later cycle and its value is final; the ordering is the requesters' responsibility.
- A requester must hold valid/addr/data stable until ready. The block never drops a stalled request.

## Timing
- Reset (`rstN=0` at an edge), next-cycle values:
  - `regWrite=0`, `writeAddr=0`, `dataIn=0`, `initDone=0`;
  - both readys 0;
  - `clrCnt=1`, `starveCnt=0`, state `CLEAR`.
- Clear sequence:
  - Edges E1..E31 are the first 31 edges with `rstN=1`. Edge Ek registers clear write of xk onto the port; the register file commits it at E(k+1).
  - State becomes `RUN` and `initDone=1` at E31.
  - First grant is possible in the cycle after E31.
- Write latency:
  - A grant in cycle N (ready=1 at edge N) appears on the port after edge N.
  - The register file commits it at edge N+1.
  - Throughput: one write per cycle.
- Reset mid-operation (`CLEAR` or `RUN`): any registered, uncommitted write is dropped (`regWrite=0` after the reset edge). The full clear sequence restarts; `initDone` returns to 0.
- `rstN` dominates all other inputs.

## Test plan
- **Reset/clear:** preload x5=0xDEADBEEF, pulse `rstN` low 1 cycle, release.
  - Required: `regWrite=1` with addresses 1..31 in order, data 0.
  - Required: `initDone` rises at E31; reading x5 returns 0 after E32.
- **Single requester:** req0 (x3, 0x00000011) in first `RUN` cycle.
  - Required: `req0Ready=1` the same cycle; port shows x3/0x11 next cycle; x3 reads 0x11 one edge later.
- **Contention:** req0 continuously valid (x1..), req1 (x7, 0xA5A5A5A5) held.
  - Required with `STARVE_LIMIT=4`: req1 stalls exactly 4 cycles, then is granted in the 5th; req0 stalls that cycle; `starveCnt` then returns to 0.
- **Address 0:** req0 (x0, 0xFFFFFFFF) and req1 (x9, 0x12345678) together.
  - Required: both readys=1 same cycle; only x9 written; x0 reads 0.
- **Same-address conflict:** req0 (x4, 0x1) and req1 (x4, 0x2) together, no starvation.
  - Required: x4=0x1 committed, then x4=0x2 next cycle.
- **Reset mid-RUN:** grant req0 (x6, 0x66), assert `rstN=0` at the following edge.
  - Required: `regWrite=0` after that edge, x6 not written; clear sequence restarts from x1.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Write-request and register-file write-port bundle for rf_write_arbiter.
// master: the requesters and register-file side; slave: the arbiter.
interface rf_write_arbiter_if #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int WORD_WIDTH    = 32
);
    // Requester 0: main pipeline writeback
    logic                     req0Valid;
    logic [RF_ADDR_WIDTH-1:0] req0Addr;
    logic [WORD_WIDTH-1:0]    req0Data;
    logic                     req0Ready;

    // Requester 1: multi-cycle unit writeback
    logic                     req1Valid;
    logic [RF_ADDR_WIDTH-1:0] req1Addr;
    logic [WORD_WIDTH-1:0]    req1Data;
    logic                     req1Ready;

    // Register file write port
    logic                     regWrite;
    logic [RF_ADDR_WIDTH-1:0] writeAddr;
    logic [WORD_WIDTH-1:0]    dataIn;
    logic                     initDone;

    modport master (
        output req0Valid, req0Addr, req0Data,
        input  req0Ready,
        output req1Valid, req1Addr, req1Data,
        input  req1Ready,
        input  regWrite, writeAddr, dataIn, initDone
    );

    modport slave (
        input  req0Valid, req0Addr, req0Data,
        output req0Ready,
        input  req1Valid, req1Addr, req1Data,
        output req1Ready,
        output regWrite, writeAddr, dataIn, initDone
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port controller: clears x1..x(REGS-1) after reset,
// then arbitrates the single write port between the pipeline (req0) and a
// multi-cycle unit (req1), with a starvation guard that favours req1.
module rf_write_arbiter #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int WORD_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input logic               clk,
    input logic               rstN,
    rf_write_arbiter_if.slave bus
);
    localparam int REGS = 1 << RF_ADDR_WIDTH;
    localparam logic [RF_ADDR_WIDTH-1:0] LAST_REG   = RF_ADDR_WIDTH'(REGS - 1);
    localparam logic [3:0]               STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                   state, stateNext;
    logic [RF_ADDR_WIDTH-1:0] clrCnt, clrCntNext;
    logic [3:0]               starveCnt, starveCntNext;

    logic                     regWriteNext;
    logic [RF_ADDR_WIDTH-1:0] writeAddrNext;
    logic [WORD_WIDTH-1:0]    dataInNext;
    logic                     initDoneNext;
    logic                     ready0, ready1;

    // A request "needs the port" only when it targets a nonzero register.
    logic pend0, pend1, grant0, grant1;

    assign pend0  = bus.req0Valid && (bus.req0Addr != '0);
    assign pend1  = bus.req1Valid && (bus.req1Addr != '0);
    assign grant1 = pend1 && (!pend0 || (starveCnt == STARVE_MAX));
    assign grant0 = pend0 && !grant1;

    // Next-state, next port values and ready generation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        stateNext     = state;
        clrCntNext    = clrCnt;
        starveCntNext = starveCnt;
        regWriteNext  = 1'b0;
        writeAddrNext = bus.writeAddr;
        dataInNext    = bus.dataIn;
        initDoneNext  = bus.initDone;
        ready0        = 1'b0;
        ready1        = 1'b0;

        case (state)
            CLEAR: begin
                regWriteNext  = 1'b1;
                writeAddrNext = clrCnt;
                dataInNext    = '0;
                clrCntNext    = clrCnt + RF_ADDR_WIDTH'(1);
                if (clrCnt == LAST_REG) begin
                    stateNext    = RUN;
                    initDoneNext = 1'b1;
                end
            end

            RUN: begin
                // Address-0 requests are acknowledged without using the port.
                ready0 = (bus.req0Valid && (bus.req0Addr == '0)) || grant0;
                ready1 = (bus.req1Valid && (bus.req1Addr == '0)) || grant1;

                if (grant1) begin
                    regWriteNext  = 1'b1;
                    writeAddrNext = bus.req1Addr;
                    dataInNext    = bus.req1Data;
                end else if (grant0) begin
                    regWriteNext  = 1'b1;
                    writeAddrNext = bus.req0Addr;
                    dataInNext    = bus.req0Data;
                end

                // Count consecutive stalls of a port-needing req1, saturating.
                if (pend1 && !grant1) begin
                    starveCntNext = (starveCnt == STARVE_MAX) ? starveCnt
                                                              : starveCnt + 4'd1;
                end else begin
                    starveCntNext = '0;
                end
            end

            default: stateNext = CLEAR;
        endcase

        // Reset dominates: nothing is accepted in a reset cycle.
        bus.req0Ready = ready0 && rstN;
        bus.req1Ready = ready1 && rstN;
    end

    // State, counters and registered write-port outputs; synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstN) begin
            state         <= CLEAR;
            clrCnt        <= RF_ADDR_WIDTH'(1);
            starveCnt     <= '0;
            bus.regWrite  <= 1'b0;
            bus.writeAddr <= '0;
            bus.dataIn    <= '0;
            bus.initDone  <= 1'b0;
        end else begin
            state         <= stateNext;
            clrCnt        <= clrCntNext;
            starveCnt     <= starveCntNext;
            bus.regWrite  <= regWriteNext;
            bus.writeAddr <= writeAddrNext;
            bus.dataIn    <= dataInNext;
            bus.initDone  <= initDoneNext;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a behavioural model predicts readys
// and port writes; a monitor compares every port write against the queue.
module tb_rf_write_arbiter;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk     = 1'b0;
    logic rstN    = 1'b0;
    logic preload = 1'b1;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  edge_n = 0;
    wr_t exp_q[$];

    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];

    // Reference model state
    bit          m_known = 0;
    bit          m_run   = 0;
    bit          m_init  = 0;
    bit          m_pv    = 0;
    int          m_clr   = 1;
    int          m_wait1 = 0;
    logic [4:0]  m_pa    = '0;
    logic [31:0] m_pd    = '0;

    // Requester state (held until the model says accepted)
    bit          q0v = 0, q1v = 0;
    logic [4:0]  q0a = '0, q1a = '0;
    logic [31:0] q0d = '0, q1d = '0;
    bit          dut_r1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Register file fed by the write port; reset in the same cycle blocks a commit.
    always @(posedge clk) begin
        if (preload) begin
            rf[0] <= '0;
            rf[5] <= 32'hDEADBEEF;
        end else if (rstN && bus.regWrite === 1'b1 && bus.writeAddr != 5'd0) begin
            rf[bus.writeAddr] <= bus.dataIn;
        end
    end

    // Monitor: every presented write must match the oldest expected one.
    always @(posedge clk) begin
        wr_t e;
        edge_n++;
        #1;
        if (bus.regWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", bus.regWrite, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bus.writeAddr, e.addr);
                check("write_data", bus.dataIn, e.data);
                check("write_cycle", edge_n, e.cyc);
            end
        end
    end

    // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
    task automatic cycle(input bit rst);
        bit pend0, pend1, win0, win1, r0, r1;
        @(negedge clk);
        rstN          = rst;
        bus.req0Valid = q0v;
        bus.req0Addr  = q0a;
        bus.req0Data  = q0d;
        bus.req1Valid = q1v;
        bus.req1Addr  = q1a;
        bus.req1Data  = q1d;
        #1;
        dut_r1 = bus.req1Ready;
        pend0  = q0v && (q0a != 5'd0);
        pend1  = q1v && (q1a != 5'd0);
        win0 = 0; win1 = 0; r0 = 0; r1 = 0;
        if (rst && m_run) begin
            win1 = pend1 && (!pend0 || m_wait1 >= LIMIT);
            win0 = pend0 && !win1;
            r0   = (q0v && q0a == 5'd0) || win0;
            r1   = (q1v && q1a == 5'd0) || win1;
        end
        if (m_known) begin
            check("regWrite", bus.regWrite, m_pv);
            check("initDone", bus.initDone, m_init);
            check("req0Ready", bus.req0Ready, r0);
            check("req1Ready", bus.req1Ready, r1);
        end
        if (rst && m_pv) exp_rf[m_pa] = m_pd;
        if (!rst) begin
            m_known = 1; m_run = 0; m_init = 0; m_pv = 0; m_clr = 1; m_wait1 = 0;
        end else if (!m_run) begin
            m_pv = 1;
            m_pa = 5'(m_clr);
            m_pd = '0;
            if (m_clr == 31) begin
                m_run  = 1;
                m_init = 1;
            end
            m_clr++;
        end else begin
            m_pv = win0 || win1;
            if (win1) begin
                m_pa = q1a; m_pd = q1d;
            end else if (win0) begin
                m_pa = q0a; m_pd = q0d;
            end
            if (pend1 && !win1) m_wait1 = (m_wait1 < LIMIT) ? m_wait1 + 1 : LIMIT;
            else                m_wait1 = 0;
        end
        if (m_pv) exp_q.push_back('{m_pa, m_pd, edge_n + 1});
        if (r0) q0v = 0;
        if (r1) q1v = 0;
        @(posedge clk);
    endtask

    task automatic check_rf(input int i);
        check($sformatf("rf_x%0d", i), rf[i], exp_rf[i]);
    endtask

    initial begin
        int stalls;
        int next_a;
        bus.req0Valid = 0; bus.req0Addr = '0; bus.req0Data = '0;
        bus.req1Valid = 0; bus.req1Addr = '0; bus.req1Data = '0;
        exp_rf[0] = '0;
        exp_rf[5] = 32'hDEADBEEF;

        // Reset with x5 preloaded
        cycle(0);
        preload = 0;
        cycle(0);
        #2 check_rf(5);

        // Clear sequence; req0 x3 waits through it
        q0v = 1; q0a = 5'd3; q0d = 32'h11;
        repeat (31) cycle(1);
        cycle(1);                       // first RUN cycle: req0 accepted
        #2 check_rf(5);
        cycle(1);
        #2 check_rf(3);

        // Contention: req0 always valid, req1 x7 held; two rounds
        next_a = 1;
        for (int round = 0; round < 2; round++) begin
            q1v = 1; q1a = 5'd7; q1d = 32'hA5A5A5A5;
            stalls = 0;
            for (int k = 0; k < 20 && q1v; k++) begin
                if (!q0v) begin
                    q0v = 1; q0a = 5'(next_a); q0d = $urandom;
                    next_a = next_a % 31 + 1;
                end
                cycle(1);
                if (!dut_r1) stalls++;
            end
            check("starve_stalls", stalls, LIMIT);
        end
        for (int k = 0; k < 4 && q0v; k++) cycle(1);

        // Address 0 from req0 alongside req1 x9
        q0v = 1; q0a = 5'd0; q0d = 32'hFFFFFFFF;
        q1v = 1; q1a = 5'd9; q1d = 32'h12345678;
        cycle(1);
        cycle(1);
        #2 check_rf(9);
        check_rf(0);

        // Same-address conflict on x4
        q0v = 1; q0a = 5'd4; q0d = 32'h1;
        q1v = 1; q1a = 5'd4; q1d = 32'h2;
        cycle(1);
        cycle(1);
        cycle(1);
        #2 check_rf(4);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if (!q0v && $urandom_range(0, 2) != 0) begin
                q0v = 1; q0a = 5'($urandom_range(0, 31)); q0d = $urandom;
            end
            if (!q1v && $urandom_range(0, 2) == 0) begin
                q1v = 1; q1a = 5'($urandom_range(0, 31)); q1d = $urandom;
            end
            cycle(1);
        end
        for (int k = 0; k < 20 && (q0v || q1v); k++) cycle(1);
        check("drain_req", {q0v, q1v}, 2'b00);
        cycle(1);
        #2;
        for (int i = 0; i < 32; i++) check_rf(i);

        // Reset right after a grant of x6: write dropped, clear restarts
        q0v = 1; q0a = 5'd6; q0d = 32'h66;
        cycle(1);
        cycle(0);
        #2 check_rf(6);
        repeat (33) cycle(1);
        #2;
        for (int i = 1; i < 32; i++) check_rf(i);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
